// File: rtl/decode_cycle.sv
// Decode stage: instruction decode, 16x20 register file with same-cycle
// writeback bypass, and the D/E pipeline register feeding execute.
module decode_cycle #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [19:0]       InstrD,
  input  logic [ADDR_W-1:0] PCD,
  input  logic [ADDR_W-1:0] PCPlus4D,
  input  logic              FlushE,
  input  logic              RegWriteW,
  input  logic [3:0]        RdW,
  input  logic [DATA_W-1:0] ResultW,
  output logic [3:0]        Rs1D,
  output logic [3:0]        Rs2D,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              ResultSrcE,
  output logic              BranchE,
  output logic              ALUSrcE,
  output logic [2:0]        ALUControlE,
  output logic [DATA_W-1:0] RD1E,
  output logic [DATA_W-1:0] RD2E,
  output logic [DATA_W-1:0] ImmExtE,
  output logic [3:0]        Rs1E,
  output logic [3:0]        Rs2E,
  output logic [3:0]        RdE,
  output logic [ADDR_W-1:0] PCE,
  output logic [ADDR_W-1:0] PCPlus4E,
  output logic              IllegalE
);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_NOP  = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  typedef struct packed {
    logic              regWrite;
    logic              memWrite;
    logic              resultSrc;
    logic              branch;
    logic              aluSrc;
    logic [2:0]        aluControl;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] immExt;
    logic [3:0]        rs1;
    logic [3:0]        rs2;
    logic [3:0]        rd;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pcPlus4;
    logic              illegal;
  } deBundle_t;

  logic [3:0]        opcode;
  logic [3:0]        fieldA;
  logic [3:0]        fieldB;
  logic [3:0]        fieldC;
  logic [DATA_W-1:0] immSext;
  logic [DATA_W-1:0] immBranch;

  logic              decRegWrite;
  logic              decMemWrite;
  logic              decResultSrc;
  logic              decBranch;
  logic              decAluSrc;
  logic [2:0]        decAluControl;
  logic [DATA_W-1:0] decImm;
  logic [3:0]        decRs1;
  logic [3:0]        decRs2;
  logic [3:0]        decRd;
  logic              decIllegal;

  logic [DATA_W-1:0] regFile [0:15];
  logic              wbEnable;
  logic [DATA_W-1:0] rd1Val;
  logic [DATA_W-1:0] rd2Val;

  deBundle_t         deNext;
  deBundle_t         deReg;

  assign opcode    = InstrD[19:16];
  assign fieldA    = InstrD[15:12];
  assign fieldB    = InstrD[11:8];
  assign fieldC    = InstrD[7:4];
  assign immSext   = {{(DATA_W-8){InstrD[7]}}, InstrD[7:0]};
  // Branch offset is word-scaled after extension, so 0xFF becomes ...FFFC.
  assign immBranch = {immSext[DATA_W-3:0], 2'b00};

  // Instruction decode: opcode map to control, indices and immediate.
  always_comb begin
    decRegWrite   = 1'b0;
    decMemWrite   = 1'b0;
    decResultSrc  = 1'b0;
    decBranch     = 1'b0;
    decAluSrc     = 1'b0;
    decAluControl = ALU_ADD;
    decImm        = {DATA_W{1'b0}};
    decRs1        = 4'h0;
    decRs2        = 4'h0;
    decRd         = 4'h0;
    decIllegal    = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        decRd       = fieldA;
        decRs1      = fieldB;
        decRs2      = fieldC;
        decRegWrite = 1'b1;
        case (opcode)
          OP_SUB:  decAluControl = ALU_SUB;
          OP_AND:  decAluControl = ALU_AND;
          OP_OR:   decAluControl = ALU_OR;
          default: decAluControl = ALU_ADD;
        endcase
      end
      OP_ADDI: begin
        decRd       = fieldA;
        decRs1      = fieldB;
        decImm      = immSext;
        decAluSrc   = 1'b1;
        decRegWrite = 1'b1;
      end
      OP_LW: begin
        decRd        = fieldA;
        decRs1       = fieldB;
        decImm       = immSext;
        decAluSrc    = 1'b1;
        decRegWrite  = 1'b1;
        decResultSrc = 1'b1;
      end
      OP_SW: begin
        decRs2      = fieldA;
        decRs1      = fieldB;
        decImm      = immSext;
        decAluSrc   = 1'b1;
        decMemWrite = 1'b1;
      end
      OP_BEQ: begin
        decRs1        = fieldA;
        decRs2        = fieldB;
        decImm        = immBranch;
        decAluControl = ALU_SUB;
        decBranch     = 1'b1;
      end
      OP_NOP: begin
        decIllegal = 1'b0;
      end
      default: begin
        decIllegal = 1'b1;
      end
    endcase
  end

  assign Rs1D = decRs1;
  assign Rs2D = decRs2;

  assign wbEnable = RegWriteW && (RdW != 4'h0);

  // Register file storage; r0 is never written so it always reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        regFile[i] <= {DATA_W{1'b0}};
      end
    end else if (wbEnable) begin
      regFile[RdW] <= ResultW;
    end
  end

  // Writeback data bypasses the array when it targets the register being read.
  assign rd1Val = (decRs1 == 4'h0)                  ? {DATA_W{1'b0}} :
                  (wbEnable && (RdW == decRs1))     ? ResultW        :
                                                      regFile[decRs1];
  assign rd2Val = (decRs2 == 4'h0)                  ? {DATA_W{1'b0}} :
                  (wbEnable && (RdW == decRs2))     ? ResultW        :
                                                      regFile[decRs2];

  // Next D/E contents: a flush loads an all-zero bubble.
  always_comb begin
    deNext = '0;
    if (FlushE) begin
      deNext = '0;
    end else begin
      deNext.regWrite   = decRegWrite;
      deNext.memWrite   = decMemWrite;
      deNext.resultSrc  = decResultSrc;
      deNext.branch     = decBranch;
      deNext.aluSrc     = decAluSrc;
      deNext.aluControl = decAluControl;
      deNext.rd1        = rd1Val;
      deNext.rd2        = rd2Val;
      deNext.immExt     = decImm;
      deNext.rs1        = decRs1;
      deNext.rs2        = decRs2;
      deNext.rd         = decRd;
      deNext.pc         = PCD;
      deNext.pcPlus4    = PCPlus4D;
      deNext.illegal    = decIllegal;
    end
  end

  // D/E pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deReg <= '0;
    end else begin
      deReg <= deNext;
    end
  end

  assign RegWriteE   = deReg.regWrite;
  assign MemWriteE   = deReg.memWrite;
  assign ResultSrcE  = deReg.resultSrc;
  assign BranchE     = deReg.branch;
  assign ALUSrcE     = deReg.aluSrc;
  assign ALUControlE = deReg.aluControl;
  assign RD1E        = deReg.rd1;
  assign RD2E        = deReg.rd2;
  assign ImmExtE     = deReg.immExt;
  assign Rs1E        = deReg.rs1;
  assign Rs2E        = deReg.rs2;
  assign RdE         = deReg.rd;
  assign PCE         = deReg.pc;
  assign PCPlus4E    = deReg.pcPlus4;
  assign IllegalE    = deReg.illegal;

endmodule

// File: tb/tb_decode_cycle.sv
// Directed-vector bench for decode_cycle: decode table, bypass, flush,
// illegal opcodes and asynchronous reset behaviour.
module tb_decode_cycle;

  logic        clk;
  logic        rst;
  logic [19:0] InstrD;
  logic [19:0] PCD;
  logic [19:0] PCPlus4D;
  logic        FlushE;
  logic        RegWriteW;
  logic [3:0]  RdW;
  logic [19:0] ResultW;
  logic [3:0]  Rs1D;
  logic [3:0]  Rs2D;
  logic        RegWriteE;
  logic        MemWriteE;
  logic        ResultSrcE;
  logic        BranchE;
  logic        ALUSrcE;
  logic [2:0]  ALUControlE;
  logic [19:0] RD1E;
  logic [19:0] RD2E;
  logic [19:0] ImmExtE;
  logic [3:0]  Rs1E;
  logic [3:0]  Rs2E;
  logic [3:0]  RdE;
  logic [19:0] PCE;
  logic [19:0] PCPlus4E;
  logic        IllegalE;

  int checks = 0;
  int errors = 0;

  decode_cycle #(.DATA_W(20), .ADDR_W(20)) dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .FlushE(FlushE), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
    .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .IllegalE(IllegalE)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [19:0] instr;
    logic [19:0] pc;
    logic        flush;
    logic        wen;
    logic [3:0]  rdW;
    logic [19:0] resW;
    logic [3:0]  eRs1D;
    logic [3:0]  eRs2D;
    logic        eRegWrite;
    logic        eMemWrite;
    logic        eResSrc;
    logic        eBranch;
    logic        eAluSrc;
    logic [2:0]  eAlu;
    logic [19:0] eRd1;
    logic [19:0] eRd2;
    logic [19:0] eImm;
    logic [3:0]  eRs1;
    logic [3:0]  eRs2;
    logic [3:0]  eRd;
    logic        eIll;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, " RegWriteE"}, {31'd0, RegWriteE}, 32'd0);
    chk({tag, " MemWriteE"}, {31'd0, MemWriteE}, 32'd0);
    chk({tag, " ResultSrcE"}, {31'd0, ResultSrcE}, 32'd0);
    chk({tag, " BranchE"}, {31'd0, BranchE}, 32'd0);
    chk({tag, " ALUSrcE"}, {31'd0, ALUSrcE}, 32'd0);
    chk({tag, " ALUControlE"}, {29'd0, ALUControlE}, 32'd0);
    chk({tag, " RD1E"}, {12'd0, RD1E}, 32'd0);
    chk({tag, " RD2E"}, {12'd0, RD2E}, 32'd0);
    chk({tag, " ImmExtE"}, {12'd0, ImmExtE}, 32'd0);
    chk({tag, " Rs1E"}, {28'd0, Rs1E}, 32'd0);
    chk({tag, " Rs2E"}, {28'd0, Rs2E}, 32'd0);
    chk({tag, " RdE"}, {28'd0, RdE}, 32'd0);
    chk({tag, " PCE"}, {12'd0, PCE}, 32'd0);
    chk({tag, " PCPlus4E"}, {12'd0, PCPlus4E}, 32'd0);
    chk({tag, " IllegalE"}, {31'd0, IllegalE}, 32'd0);
  endtask

  initial begin
    //          instr     pc        fl    wen   rdW   resW      rs1D  rs2D  RW    MW    RS    BR    AS    alu     rd1       rd2       imm       rs1   rs2   rd    ill
    vecs[0]  = '{20'hF0000, 20'h00010, 1'b0, 1'b1, 4'h2, 20'h00005, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 20'h00000, 20'h00000, 20'h00000, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[1]  = '{20'hF0000, 20'h00014, 1'b0, 1'b1, 4'h3, 20'h00007, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 20'h00000, 20'h00000, 20'h00000, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[2]  = '{20'h01230, 20'h00100, 1'b0, 1'b0, 4'h0, 20'h00000, 4'h2, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 20'h00005, 20'h00007, 20'h00000, 4'h2, 4'h3, 4'h1, 1'b0};
    vecs[3]  = '{20'h45440, 20'h00104, 1'b0, 1'b1, 4'h4, 20'hABCDE, 4'h4, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 20'hABCDE, 20'h00000, 20'h00040, 4'h4, 4'h0, 4'h5, 1'b0};
    vecs[4]  = '{20'hF0000, 20'h00108, 1'b0, 1'b1, 4'h0, 20'h12345, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 20'h00000, 20'h00000, 20'h00000, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[5]  = '{20'h07040, 20'h0010C, 1'b0, 1'b0, 4'h0, 20'h00000, 4'h0, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 20'h00000, 20'hABCDE, 20'h00000, 4'h0, 4'h4, 4'h7, 1'b0};
    vecs[6]  = '{20'h712FF, 20'h00110, 1'b0, 1'b0, 4'h0, 20'h00000, 4'h1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 20'h00000, 20'h00005, 20'hFFFFC, 4'h1, 4'h2, 4'h0, 1'b0};
    vecs[7]  = '{20'h63210, 20'h00114, 1'b1, 1'b1, 4'h6, 20'h0BEEF, 4'h2, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 20'h00000, 20'h00000, 20'h00000, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[8]  = '{20'h66110, 20'h00118, 1'b0, 1'b0, 4'h0, 20'h00000, 4'h1, 4'h6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 20'h00000, 20'h0BEEF, 20'h00010, 4'h1, 4'h6, 4'h0, 1'b0};
    vecs[9]  = '{20'h91230, 20'h0011C, 1'b0, 1'b0, 4'h0, 20'h00000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 20'h00000, 20'h00000, 20'h00000, 4'h0, 4'h0, 4'h0, 1'b1};
    vecs[10] = '{20'hF0000, 20'h00120, 1'b0, 1'b0, 4'h0, 20'h00000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 20'h00000, 20'h00000, 20'h00000, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[11] = '{20'h5A3F8, 20'h00124, 1'b0, 1'b0, 4'h0, 20'h00000, 4'h3, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 20'h00007, 20'h00000, 20'hFFFF8, 4'h3, 4'h0, 4'hA, 1'b0};
    vecs[12] = '{20'h12320, 20'h00128, 1'b0, 1'b1, 4'h2, 20'h00009, 4'h3, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 20'h00007, 20'h00009, 20'h00000, 4'h3, 4'h2, 4'h2, 1'b0};
    vecs[13] = '{20'h24230, 20'h0012C, 1'b0, 1'b1, 4'hF, 20'hFFFFF, 4'h2, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 20'h00009, 20'h00007, 20'h00000, 4'h2, 4'h3, 4'h4, 1'b0};
    vecs[14] = '{20'h35F20, 20'h00130, 1'b0, 1'b0, 4'h0, 20'h00000, 4'hF, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b011, 20'hFFFFF, 20'h00009, 20'h00000, 4'hF, 4'h2, 4'h5, 1'b0};
    vecs[15] = '{20'hE0000, 20'h00134, 1'b0, 1'b0, 4'h0, 20'h00000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 20'h00000, 20'h00000, 20'h00000, 4'h0, 4'h0, 4'h0, 1'b1};
    vecs[16] = '{20'h4107F, 20'h00138, 1'b0, 1'b0, 4'h0, 20'h00000, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 20'h00000, 20'h00000, 20'h0007F, 4'h0, 4'h0, 4'h1, 1'b0};
    vecs[17] = '{20'h72301, 20'h0013C, 1'b0, 1'b0, 4'h0, 20'h00000, 4'h2, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 20'h00009, 20'h00007, 20'h00004, 4'h2, 4'h3, 4'h0, 1'b0};

    rst = 1'b0; InstrD = 20'hF0000; PCD = 20'h0; PCPlus4D = 20'h0; FlushE = 1'b0;
    RegWriteW = 1'b0; RdW = 4'h0; ResultW = 20'h0;
    #1 rst = 1'b1;
    #2 chkAllZero("por");
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      InstrD = vecs[i].instr; PCD = vecs[i].pc; PCPlus4D = vecs[i].pc + 20'd4;
      FlushE = vecs[i].flush; RegWriteW = vecs[i].wen; RdW = vecs[i].rdW; ResultW = vecs[i].resW;
      #1;
      chk($sformatf("v%0d Rs1D", i), {28'd0, Rs1D}, {28'd0, vecs[i].eRs1D});
      chk($sformatf("v%0d Rs2D", i), {28'd0, Rs2D}, {28'd0, vecs[i].eRs2D});
      @(posedge clk); #1;
      chk($sformatf("v%0d RegWriteE", i), {31'd0, RegWriteE}, {31'd0, vecs[i].eRegWrite});
      chk($sformatf("v%0d MemWriteE", i), {31'd0, MemWriteE}, {31'd0, vecs[i].eMemWrite});
      chk($sformatf("v%0d ResultSrcE", i), {31'd0, ResultSrcE}, {31'd0, vecs[i].eResSrc});
      chk($sformatf("v%0d BranchE", i), {31'd0, BranchE}, {31'd0, vecs[i].eBranch});
      chk($sformatf("v%0d ALUSrcE", i), {31'd0, ALUSrcE}, {31'd0, vecs[i].eAluSrc});
      chk($sformatf("v%0d ALUControlE", i), {29'd0, ALUControlE}, {29'd0, vecs[i].eAlu});
      chk($sformatf("v%0d RD1E", i), {12'd0, RD1E}, {12'd0, vecs[i].eRd1});
      chk($sformatf("v%0d RD2E", i), {12'd0, RD2E}, {12'd0, vecs[i].eRd2});
      chk($sformatf("v%0d ImmExtE", i), {12'd0, ImmExtE}, {12'd0, vecs[i].eImm});
      chk($sformatf("v%0d Rs1E", i), {28'd0, Rs1E}, {28'd0, vecs[i].eRs1});
      chk($sformatf("v%0d Rs2E", i), {28'd0, Rs2E}, {28'd0, vecs[i].eRs2});
      chk($sformatf("v%0d RdE", i), {28'd0, RdE}, {28'd0, vecs[i].eRd});
      chk($sformatf("v%0d IllegalE", i), {31'd0, IllegalE}, {31'd0, vecs[i].eIll});
      chk($sformatf("v%0d PCE", i), {12'd0, PCE}, vecs[i].flush ? 32'd0 : {12'd0, vecs[i].pc});
      chk($sformatf("v%0d PCPlus4E", i), {12'd0, PCPlus4E},
          vecs[i].flush ? 32'd0 : {12'd0, vecs[i].pc + 20'd4});
    end

    // Mid-cycle async reset with a loaded D/E register and non-zero registers.
    RegWriteW = 1'b0; FlushE = 1'b0;
    chk("pre-rst PCE", {12'd0, PCE}, 32'h0013C);
    #2 rst = 1'b1;
    #1 chkAllZero("midrst");
    @(posedge clk); #1 chkAllZero("rsthold");
    @(negedge clk) rst = 1'b0;

    for (int r = 1; r < 16; r++) begin
      logic [3:0] idx;
      idx = r[3:0];
      InstrD = {4'h0, 4'h0, idx, idx, 4'h0}; PCD = 20'h00200; PCPlus4D = 20'h00204;
      @(posedge clk); #1;
      chk($sformatf("postrst r%0d RD1E", r), {12'd0, RD1E}, 32'd0);
      chk($sformatf("postrst r%0d RD2E", r), {12'd0, RD2E}, 32'd0);
      chk($sformatf("postrst r%0d Rs1E", r), {28'd0, Rs1E}, {28'd0, idx});
      chk($sformatf("postrst r%0d RegWriteE", r), {31'd0, RegWriteE}, 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
- Decode stage of the 5-stage pipeline. Consumes the fetch stage outputs (InstrD, PCD, PCPlus4D) and decodes the 20-bit instruction.
- Reads the 16x20 register file, which it owns and which is written back from the W stage.
- Latches everything into the D/E pipeline register feeding execute.
- Also exports source register indices to the hazard unit.

Parameters:
DATA_W, 20, register/operand width
ADDR_W, 20, PC width (matches fetch stage)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
InstrD  in  20  instruction from fetch
PCD  in  ADDR_W  PC of InstrD
PCPlus4D  in  ADDR_W  PCD+4
FlushE  in  1  load bubble into D/E register
RegWriteW  in  1  writeback enable
RdW  in  4  writeback register index
ResultW  in  DATA_W  writeback data
Rs1D  out  4  decoded rs1 index (combinational, to hazard unit)
Rs2D  out  4  decoded rs2 index (combinational)
RegWriteE  out  1  registered control
MemWriteE  out  1  registered control
ResultSrcE  out  1  0=ALU, 1=memory
BranchE  out  1  BEQ in execute
ALUSrcE  out  1  0=RD2, 1=immediate
ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or
RD1E  out  DATA_W  rs1 value
RD2E  out  DATA_W  rs2 value
ImmExtE  out  DATA_W  extended immediate
Rs1E  out  4  rs1 index
Rs2E  out  4  rs2 index
RdE  out  4  destination index
PCE  out  ADDR_W  PC
PCPlus4E  out  ADDR_W  PC+4
IllegalE  out  1  opcode not in map (registered)

Behaviour:
- Format: op=InstrD[19:16], a=[15:12], b=[11:8], c=[7:4], imm8=[7:0].
- Opcode map:
  - 0x0 ADD, 0x1 SUB, 0x2 AND, 0x3 OR: rd=a, rs1=b, rs2=c, RegWrite=1, ALUSrc=0, imm=0.
  - 0x4 ADDI: rd=a, rs1=b, rs2=0, imm=sext(imm8), ALUSrc=1, add, RegWrite=1.
  - 0x5 LW: rd=a, rs1=b, rs2=0, imm=sext(imm8), ALUSrc=1, add, RegWrite=1, ResultSrc=1.
  - 0x6 SW: rs2=a, rs1=b, rd=0, imm=sext(imm8), ALUSrc=1, add, MemWrite=1.
  - 0x7 BEQ: rs1=a, rs2=b, rd=0, imm=sext(imm8)<<2, sub, Branch=1.
  - 0xF NOP: all controls 0, indices 0.
  - 0x8-0xE: decode as NOP and set IllegalE=1 for that instruction.
- Sign extension is to DATA_W. The BEQ shift is applied after extension, so imm8=0xFF gives 0xFFFFC.
- Register file:
  - 16 entries; r0 reads 0 always.
  - Write on posedge when RegWriteW=1 and RdW!=0; a write to r0 is discarded.
  - Read is combinational. Same-cycle bypass: if RegWriteW=1, RdW!=0 and RdW equals the read index, the read returns ResultW.
- D/E register:
  - Loads on every posedge. Latency is 1 cycle from InstrD to the E outputs.
  - FlushE=1: bubble loaded instead. All control outputs, IllegalE, indices, RD1E/RD2E/ImmExtE, PCE and PCPlus4E are set to 0.
  - The register file write still occurs in the same cycle as a flush.
- Reset (async, rst=1):
  - All E outputs go to 0 immediately, and the register file clears to 0.
  - Held while rst=1; normal operation resumes on the first posedge after deassertion.
  - Reset mid-stream discards the in-flight D/E contents.
- Rs1D/Rs2D are purely combinational from InstrD, with no register and no reset dependency.

Test Plan:
- Reset: assert rst mid-cycle with a non-zero D/E → all E outputs 0 before the next edge; after release, reading r1..r15 yields 0.
- ADD decode: write r2=0x00005, r3=0x00007 via W port; InstrD=0x0_1_2_3, PCD=0x00100, PCPlus4D=0x00104 → next cycle RegWriteE=1, ALUControlE=000, RD1E=5, RD2E=7, RdE=1, PCE=0x00100, PCPlus4E=0x00104.
- Bypass and r0: RegWriteW=1, RdW=4, ResultW=0xABCDE with InstrD=0x4_5_4_0 (ADDI r5,r4,0x40) in the same cycle → RD1E=0xABCDE, ImmExtE=0x00040. Then RdW=0, ResultW=0x12345; a later read of r0 → RD1E=0.
- BEQ negative offset: InstrD=0x7_1_2_FF → BranchE=1, ALUControlE=001, ImmExtE=0xFFFFC, RdE=0, RegWriteE=0.
- Flush: InstrD=SW (0x6_3_2_10) with FlushE=1 → next cycle all E outputs 0, MemWriteE=0. A simultaneous W write to r6 is still visible on a later read.
- Illegal: InstrD=0x9_1_2_3 → IllegalE=1, RegWriteE=0, MemWriteE=0, BranchE=0. Next cycle with a NOP (0xF0000) → IllegalE=0.
